prog_mem_checker: RTL and testbench
===================================

// Module: prog_mem_checker
// PURPOSE
//  Synthesizable, parametrised program-memory/self-check block for CPU bring-up.
//  - Holds test vectors {instruction, expected value} loaded over a valid/ready port.
//  - Serves instructions to the CPU and checks that the PC steps sequentially.
//  - Compares the destination register of each retired instruction against the expected value.
//  - Stops on a HALT opcode or on a fault.
// PARAMETERS
//  ADDR_W      10   PC/address width
//  DEPTH       1024 vector entries (<= 2**ADDR_W)
//  INSTR_W     22   instruction width; opcode = instr[INSTR_W-1 -: OPC_W]
//  OPC_W       4    opcode width
//  DATA_W      9    register/expected-value width
//  NUM_REGS    7    CPU registers observed
//  REGSEL_LSB  9    dest-reg field = instr[REGSEL_LSB +: $clog2(NUM_REGS)]
//  HALT_OPC    15   opcode that ends the run
//  MAX_ERRORS  1    register mismatches tolerated before FAULT (>=1)
// PORTS
//  clock       in   1                  single clock, all logic posedge
//  reset_n     in   1                  synchronous, active-low
//  load_valid  in   1                  vector write request
//  load_ready  out  1                  high only in IDLE
//  load_addr   in   ADDR_W             vector index
//  load_word   in   INSTR_W+DATA_W     {instr, expected}
//  start       in   1                  pulse: IDLE/HALTED/FAULT -> ARM
//  address     in   ADDR_W             CPU PC
//  registers   in   NUM_REGS*DATA_W    packed CPU register file, reg0 in LSBs
//  ram_data    out  INSTR_W            instruction to CPU
//  pc_reset    out  1                  holds CPU PC at 0
//  state       out  3                  pmc_state_t encoding
//  error_count out  16                 saturating register-mismatch count
//  seq_error   out  1                  sticky: PC out of sequence
//  err_addr    out  ADDR_W             address of first error
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, ram_data=0, pc_reset=1, error_count=0, seq_error=0, err_addr=0.
//   - Vector memory is NOT reset; contents survive reset mid-run.
//  IDLE:
//   - load_ready=1; write occurs when load_valid&&load_ready.
//   - load_addr>=DEPTH is dropped silently, with no error.
//   - start -> ARM; a same-cycle load is still written.
//  ARM:
//   - pc_reset=1; ram_data<=mem[0].instr.
//   - When address==0 is sampled: pc_reset<=0, last<=0, prev<=mem[0], then -> RUN.
//  RUN, evaluated each posedge in this priority:
//   1. Expected address: 0 if address==0 (resync allowed), else last+1, mod 2**ADDR_W.
//      On mismatch: seq_error<=1, err_addr<=address if first error, -> FAULT.
//   2. If last>0 and registers[prev.regsel]!=prev.expected: error_count+1 (saturating).
//      If that reaches MAX_ERRORS -> FAULT.
//   3. If mem[address].opcode==HALT_OPC -> HALTED; this takes precedence over the
//      step-2 FAULT only when no error was counted this cycle.
//   4. Otherwise ram_data<=mem[address].instr, prev<=mem[address], last<=expected address.
//  One-cycle latency: instruction for address A appears on ram_data the edge after A is sampled.
//  HALTED/FAULT:
//   - ram_data, pc_reset=1 and counters hold until start (-> ARM, counters cleared) or reset.
//  address>=DEPTH in RUN reads as vector 0.
// CONFIGURATION
//  PMC_REG_CHECK_EN defined:
//   - Register compare (step 2) is active.
//  PMC_REG_CHECK_EN undefined:
//   - Step 2 is removed; registers is unused.
//   - error_count stays 0; only sequence and HALT checks remain.
// STRUCTURE
//  Package prog_mem_pkg:
//   - pmc_state_t enum {IDLE,ARM,RUN,HALTED,FAULT}.
//   - vec_t packed struct {instr, expected}.
//   - Field-extract functions for opcode and regsel.
//  Sub-module pmc_vec_mem:
//   - DEPTH x (INSTR_W+DATA_W) array.
//   - One sync write port and one combinational read port.
// TESTING
//  1. Load 4 vectors (MOVI r0..r2 = 5,9,3; HALT), start, CPU steps 0,1,2,3 with correct regs
//     -> state=HALTED, error_count=0, seq_error=0.
//  2. Same program with r1=8 at the check after address 2
//     -> error_count=1, err_addr=2, state=FAULT (MAX_ERRORS=1).
//  3. PC sequence 0,1,3 -> seq_error=1, err_addr=3, state=FAULT, pc_reset=1.
//  4. Assert reset_n=0 for one cycle mid-RUN at address 2 -> state=IDLE, pc_reset=1.
//     Then start and rerun -> HALTED; this proves the memory was retained.
//  5. In IDLE, load_valid with load_addr=DEPTH and start in the same cycle
//     -> write dropped, state=ARM, mem[0] on ram_data next edge.
//  6. Build without PMC_REG_CHECK_EN, rerun scenario 2 -> HALTED, error_count=0.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types and field helpers for the program-memory checker.
// Default widths of vec_t match the checker's default parameters.
package prog_mem_pkg;

  localparam int unsigned PMC_INSTR_W = 22;
  localparam int unsigned PMC_DATA_W  = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RUN    = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } pmc_state_t;

  typedef struct packed {
    logic [PMC_INSTR_W-1:0] instr;
    logic [PMC_DATA_W-1:0]  expected;
  } vec_t;

  function automatic logic [31:0] field_of(input logic [63:0] word,
                                           input int unsigned lsb,
                                           input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((word >> lsb) & mask);
  endfunction

  // Opcode sits in the top opc_w bits of the instruction.
  function automatic logic [31:0] opcode_of(input logic [63:0] instr,
                                            input int unsigned instr_w,
                                            input int unsigned opc_w);
    return field_of(instr, instr_w - opc_w, opc_w);
  endfunction

  function automatic logic [31:0] regsel_of(input logic [63:0] instr,
                                            input int unsigned regsel_lsb,
                                            input int unsigned sel_w);
    return field_of(instr, regsel_lsb, sel_w);
  endfunction

endpackage

// File: rtl/pmc_vec_mem.sv
// Vector storage: DEPTH words of {instr, expected}, one synchronous write
// port and one combinational read port. Contents are never reset.
module pmc_vec_mem #(
  parameter int DEPTH  = 1024,
  parameter int WORD_W = 31,
  parameter int AW     = 10
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_mem_checker.sv
// Program memory + self-check for CPU bring-up: serves instructions, checks PC
// sequencing and retired register values. Optional macro: PMC_REG_CHECK_EN.
module prog_mem_checker
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int INSTR_W    = 22,
  parameter int OPC_W      = 4,
  parameter int DATA_W     = 9,
  parameter int NUM_REGS   = 7,
  parameter int REGSEL_LSB = 9,
  parameter int HALT_OPC   = 15,
  parameter int MAX_ERRORS = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [INSTR_W+DATA_W-1:0]  load_word,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          address,
  input  logic [NUM_REGS*DATA_W-1:0] registers,
  output logic [INSTR_W-1:0]         ram_data,
  output logic                       pc_reset,
  output logic [2:0]                 state,
  output logic [15:0]                error_count,
  output logic                       seq_error,
  output logic [ADDR_W-1:0]          err_addr
);

  localparam int WORD_W = INSTR_W + DATA_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  pmc_state_t          state_reg, state_next;
  logic [INSTR_W-1:0]  ram_data_reg, ram_data_next;
  logic                pc_reset_reg, pc_reset_next;
  logic [15:0]         err_cnt_reg, err_cnt_next;
  logic                seq_error_reg, seq_error_next;
  logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;
  logic                err_seen_reg, err_seen_next;
  logic [ADDR_W-1:0]   last_reg, last_next;
  logic [WORD_W-1:0]   prev_reg, prev_next;

  logic                load_in_range;
  logic                run_in_range;
  logic                wr_en;
  logic [MEM_AW-1:0]   rd_addr;
  logic [WORD_W-1:0]   rd_word;
  logic [INSTR_W-1:0]  rd_instr;
  logic                rd_is_halt;
  logic [ADDR_W-1:0]   exp_addr;
  logic [15:0]         err_cnt_inc;
  logic                reg_mismatch;

  assign load_ready    = (state_reg == IDLE);
  assign load_in_range = 32'(load_addr) < 32'(DEPTH);
  assign run_in_range  = 32'(address) < 32'(DEPTH);
  assign wr_en         = load_valid && load_ready && load_in_range;

  // ARM always fetches entry 0; out-of-range PCs in RUN also alias to entry 0.
  assign rd_addr = (state_reg == RUN && run_in_range) ? address[MEM_AW-1:0] : '0;

  pmc_vec_mem #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .AW     (MEM_AW)
  ) u_vec_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (load_addr[MEM_AW-1:0]),
    .wr_data (load_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  assign rd_instr    = rd_word[DATA_W +: INSTR_W];
  assign rd_is_halt  = opcode_of(64'(rd_instr), INSTR_W, OPC_W) == 32'(HALT_OPC);
  assign exp_addr    = (address == '0) ? '0 : last_reg + ADDR_W'(1);
  assign err_cnt_inc = (err_cnt_reg == 16'hFFFF) ? err_cnt_reg : err_cnt_reg + 16'd1;

`ifdef PMC_REG_CHECK_EN
  logic [DATA_W-1:0] reg_file [NUM_REGS];
  logic [SEL_W-1:0]  prev_sel;
  logic [DATA_W-1:0] prev_reg_val;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    assign reg_file[gi] = registers[gi*DATA_W +: DATA_W];
  end

  assign prev_sel     = SEL_W'(regsel_of(64'(prev_reg[DATA_W +: INSTR_W]), REGSEL_LSB, SEL_W));
  assign prev_reg_val = (32'(prev_sel) < 32'(NUM_REGS)) ? reg_file[prev_sel] : '0;
  // The instruction at PC 0 is never checked: last==0 means nothing has retired yet.
  assign reg_mismatch = (last_reg != '0) && (prev_reg_val != prev_reg[DATA_W-1:0]);
`else
  logic unused_reg_check;
  assign unused_reg_check = ^{registers, prev_reg};
  assign reg_mismatch     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ram_data_reg  <= '0;
      pc_reset_reg  <= 1'b1;
      err_cnt_reg   <= '0;
      seq_error_reg <= 1'b0;
      err_addr_reg  <= '0;
      err_seen_reg  <= 1'b0;
      last_reg      <= '0;
      prev_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      ram_data_reg  <= ram_data_next;
      pc_reset_reg  <= pc_reset_next;
      err_cnt_reg   <= err_cnt_next;
      seq_error_reg <= seq_error_next;
      err_addr_reg  <= err_addr_next;
      err_seen_reg  <= err_seen_next;
      last_reg      <= last_next;
      prev_reg      <= prev_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ram_data_next  = ram_data_reg;
    pc_reset_next  = pc_reset_reg;
    err_cnt_next   = err_cnt_reg;
    seq_error_next = seq_error_reg;
    err_addr_next  = err_addr_reg;
    err_seen_next  = err_seen_reg;
    last_next      = last_reg;
    prev_next      = prev_reg;
    unique case (state_reg)
      IDLE, HALTED, FAULT: begin
        if (start) begin
          state_next     = ARM;
          pc_reset_next  = 1'b1;
          err_cnt_next   = '0;
          seq_error_next = 1'b0;
          err_addr_next  = '0;
          err_seen_next  = 1'b0;
        end
      end
      ARM: begin
        pc_reset_next = 1'b1;
        ram_data_next = rd_instr;
        if (address == '0) begin
          pc_reset_next = 1'b0;
          last_next     = '0;
          prev_next     = rd_word;
          state_next    = RUN;
        end
      end
      RUN: begin
        if (address != exp_addr) begin
          seq_error_next = 1'b1;
          if (!err_seen_reg) begin
            err_addr_next = address;
            err_seen_next = 1'b1;
          end
          state_next    = FAULT;
          pc_reset_next = 1'b1;
        end else begin
          if (reg_mismatch) begin
            err_cnt_next = err_cnt_inc;
            if (!err_seen_reg) begin
              err_addr_next = address;
              err_seen_next = 1'b1;
            end
          end
          // A counted error that hits the limit outranks HALT on the same cycle.
          if (reg_mismatch && (32'(err_cnt_inc) >= 32'(MAX_ERRORS))) begin
            state_next    = FAULT;
            pc_reset_next = 1'b1;
          end else if (rd_is_halt) begin
            state_next    = HALTED;
            pc_reset_next = 1'b1;
          end else begin
            ram_data_next = rd_instr;
            prev_next     = rd_word;
            last_next     = exp_addr;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_data    = ram_data_reg;
  assign pc_reset    = pc_reset_reg;
  assign state       = state_reg;
  assign error_count = err_cnt_reg;
  assign seq_error   = seq_error_reg;
  assign err_addr    = err_addr_reg;

endmodule

// File: tb/tb_prog_mem_checker.sv
// Directed, table-driven bench for prog_mem_checker (DEPTH reduced to 16 so
// that an out-of-range load address is expressible).
module tb_prog_mem_checker;
  import prog_mem_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int DEPTH    = 16;
  localparam int INSTR_W  = 22;
  localparam int DATA_W   = 9;
  localparam int NUM_REGS = 7;

  typedef struct {
    logic        arm;
    int          addr;
    logic [62:0] regs;
    pmc_state_t  st;
    logic [21:0] ram;
    logic        pcr;
    int          err;
    logic        seq;
    int          eaddr;
  } row_t;

  logic                       clock = 1'b0;
  logic                       reset_n;
  logic                       load_valid;
  logic                       load_ready;
  logic [ADDR_W-1:0]          load_addr;
  logic [INSTR_W+DATA_W-1:0]  load_word;
  logic                       start;
  logic [ADDR_W-1:0]          address;
  logic [NUM_REGS*DATA_W-1:0] registers;
  logic [INSTR_W-1:0]         ram_data;
  logic                       pc_reset;
  logic [2:0]                 state;
  logic [15:0]                error_count;
  logic                       seq_error;
  logic [ADDR_W-1:0]          err_addr;

  int n_vec = 0;
  int n_bad = 0;
  row_t tbl[$];
  logic [21:0] i0, i1, i2, i3;
  logic [62:0] good_regs, bad_r1, bad_r2;

  always #5 clock = ~clock;

  prog_mem_checker #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_word   (load_word),
    .start       (start),
    .address     (address),
    .registers   (registers),
    .ram_data    (ram_data),
    .pc_reset    (pc_reset),
    .state       (state),
    .error_count (error_count),
    .seq_error   (seq_error),
    .err_addr    (err_addr)
  );

  function automatic logic [21:0] mk_instr(input int opc, input int rsel, input int imm);
    return {4'(opc), 6'd0, 3'(rsel), 9'(imm)};
  endfunction

  function automatic logic [62:0] pack3(input int a, input int b, input int c);
    logic [62:0] r;
    r = '0;
    r[8:0]   = 9'(a);
    r[17:9]  = 9'(b);
    r[26:18] = 9'(c);
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got 0x%0h, want 0x%0h", idx, nm, act, exp);
    end
  endtask

  task automatic add(input logic arm, input int addr, input logic [62:0] regs, input pmc_state_t st,
                     input logic [21:0] ram, input logic pcr, input int err, input logic seq, input int eaddr);
    row_t r;
    r.arm = arm; r.addr = addr; r.regs = regs; r.st = st; r.ram = ram;
    r.pcr = pcr; r.err = err; r.seq = seq; r.eaddr = eaddr;
    tbl.push_back(r);
  endtask

  task automatic load(input int addr, input logic [21:0] instr, input int expv);
    vec_t lw;
    lw.instr    = instr;
    lw.expected = 9'(expv);
    load_valid  = 1'b1;
    load_addr   = ADDR_W'(addr);
    load_word   = lw;
    step();
    load_valid  = 1'b0;
  endtask

  // Start pulse, then ARM samples PC 0 and enters RUN with entry 0 on ram_data.
  task automatic arm(input int idx);
    start   = 1'b1;
    address = '0;
    step();
    start = 1'b0;
    check(idx, "arm_state", 32'(state), 32'(ARM));
    check(idx, "arm_seq_clr", 32'(seq_error), 32'd0);
    check(idx, "arm_err_clr", 32'(error_count), 32'd0);
    check(idx, "arm_eaddr_clr", 32'(err_addr), 32'd0);
    step();
    check(idx, "arm_run", 32'(state), 32'(RUN));
    check(idx, "arm_ram0", 32'(ram_data), 32'(i0));
    check(idx, "arm_pcr", 32'(pc_reset), 32'd0);
  endtask

  task automatic apply_row(input row_t r, input int idx);
    if (r.arm) arm(idx);
    address   = ADDR_W'(r.addr);
    registers = r.regs;
    step();
    $display("row %0d: addr=%0d state=%0d ram=0x%0h pcr=%0b err=%0d seq=%0b eaddr=%0d",
             idx, r.addr, state, ram_data, pc_reset, error_count, seq_error, err_addr);
    check(idx, "state", 32'(state), 32'(r.st));
    check(idx, "ram_data", 32'(ram_data), 32'(r.ram));
    check(idx, "pc_reset", 32'(pc_reset), 32'(r.pcr));
    check(idx, "error_count", 32'(error_count), 32'(r.err));
    check(idx, "seq_error", 32'(seq_error), 32'(r.seq));
    check(idx, "err_addr", 32'(err_addr), 32'(r.eaddr));
  endtask

  initial begin
    i0 = mk_instr(1, 0, 5);
    i1 = mk_instr(1, 1, 9);
    i2 = mk_instr(1, 2, 3);
    i3 = mk_instr(15, 0, 0);
    good_regs = pack3(5, 9, 3);
    bad_r1    = pack3(5, 8, 3);
    bad_r2    = pack3(5, 9, 4);

    // Normal run 0,1,2,3 to HALT.
    add(1'b1, 1, good_regs, RUN,    i1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 2, good_regs, RUN,    i2, 1'b0, 0, 1'b0, 0);
    add(1'b0, 3, good_regs, HALTED, i2, 1'b1, 0, 1'b0, 0);
    add(1'b0, 3, good_regs, HALTED, i2, 1'b1, 0, 1'b0, 0);
    // r1 wrong when checked at PC 2.
    add(1'b1, 1, bad_r1, RUN, i1, 1'b0, 0, 1'b0, 0);
`ifdef PMC_REG_CHECK_EN
    add(1'b0, 2, bad_r1, FAULT, i1, 1'b1, 1, 1'b0, 2);
    add(1'b0, 3, bad_r1, FAULT, i1, 1'b1, 1, 1'b0, 2);
`else
    add(1'b0, 2, bad_r1, RUN,    i2, 1'b0, 0, 1'b0, 0);
    add(1'b0, 3, bad_r1, HALTED, i2, 1'b1, 0, 1'b0, 0);
`endif
    // r2 wrong on the HALT cycle: a counted error beats HALT.
    add(1'b1, 1, bad_r2, RUN, i1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 2, bad_r2, RUN, i2, 1'b0, 0, 1'b0, 0);
`ifdef PMC_REG_CHECK_EN
    add(1'b0, 3, bad_r2, FAULT,  i2, 1'b1, 1, 1'b0, 3);
`else
    add(1'b0, 3, bad_r2, HALTED, i2, 1'b1, 0, 1'b0, 0);
`endif
    // PC jumps 1 -> 3.
    add(1'b1, 1, good_regs, RUN,   i1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 3, good_regs, FAULT, i1, 1'b1, 0, 1'b1, 3);
    add(1'b0, 4, good_regs, FAULT, i1, 1'b1, 0, 1'b1, 3);
    // Resync to 0 mid-run is allowed.
    add(1'b1, 1, good_regs, RUN,    i1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 0, good_regs, RUN,    i0, 1'b0, 0, 1'b0, 0);
    add(1'b0, 1, good_regs, RUN,    i1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 2, good_regs, RUN,    i2, 1'b0, 0, 1'b0, 0);
    add(1'b0, 3, good_regs, HALTED, i2, 1'b1, 0, 1'b0, 0);

    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_word  = '0;
    start      = 1'b0;
    address    = '0;
    registers  = '0;
    step();
    step();
    check(0, "rst_state", 32'(state), 32'(IDLE));
    check(0, "rst_ram", 32'(ram_data), 32'd0);
    check(0, "rst_pcr", 32'(pc_reset), 32'd1);
    check(0, "rst_err", 32'(error_count), 32'd0);
    check(0, "rst_seq", 32'(seq_error), 32'd0);
    check(0, "rst_eaddr", 32'(err_addr), 32'd0);
    check(0, "rst_ready", 32'(load_ready), 32'd1);
    reset_n = 1'b1;

    load(0, i0, 5);
    load(1, i1, 9);
    load(2, i2, 3);
    load(3, i3, 0);
    check(0, "load_idle", 32'(state), 32'(IDLE));

    for (int k = 0; k < tbl.size(); k++) begin
      apply_row(tbl[k], k + 1);
    end

    // Reset mid-run at PC 2, then rerun from retained memory.
    apply_row(tbl[0], 100);
    apply_row(tbl[1], 101);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    $display("mid-run reset: state=%0d pcr=%0b ram=0x%0h", state, pc_reset, ram_data);
    check(102, "mr_state", 32'(state), 32'(IDLE));
    check(102, "mr_pcr", 32'(pc_reset), 32'd1);
    check(102, "mr_ram", 32'(ram_data), 32'd0);
    check(102, "mr_ready", 32'(load_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      apply_row(tbl[k], 103 + k);
    end

    // Out-of-range load with start in the same cycle: dropped, no alias onto entry 0.
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    load_valid = 1'b1;
    load_addr  = ADDR_W'(DEPTH);
    load_word  = {mk_instr(7, 5, 9'h1AA), 9'h055};
    start      = 1'b1;
    address    = ADDR_W'(5);
    step();
    load_valid = 1'b0;
    start      = 1'b0;
    $display("oor load+start: state=%0d ready=%0b", state, load_ready);
    check(200, "oor_state", 32'(state), 32'(ARM));
    check(200, "oor_ready", 32'(load_ready), 32'd0);
    step();
    $display("arm wait pc=5: state=%0d ram=0x%0h pcr=%0b", state, ram_data, pc_reset);
    check(201, "arm_wait_state", 32'(state), 32'(ARM));
    check(201, "arm_wait_ram0", 32'(ram_data), 32'(i0));
    check(201, "arm_wait_pcr", 32'(pc_reset), 32'd1);
    address = '0;
    step();
    check(202, "arm_go_state", 32'(state), 32'(RUN));
    check(202, "arm_go_pcr", 32'(pc_reset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
